// File: rtl/pineball_pkg.sv
// Shared types and constants for the pinball game sequencer.
// The speedup constants are only consumed when PINEBALL_SPEEDUP_EN is defined.
package pineball_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RUN   = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam logic [1:0] LIVES_RESET      = 2'd3;
  localparam int         SPEED_CAP        = 4;
  localparam int         SPEEDUP_INTERVAL = 8;
  localparam int         SPEEDUP_BITS     = $clog2(SPEEDUP_INTERVAL);

endpackage

// File: rtl/pineball_axis_step.sv
// One-axis ball step: moves by speed toward the current direction and
// clamps to 0 or limit_i, flipping direction when a bound is reached.
module pineball_axis_step (
  input  logic [10:0] pos_i,
  input  logic        dir_neg_i,
  input  logic [2:0]  speed_i,
  input  logic [10:0] limit_i,
  output logic [10:0] pos_o,
  output logic        dir_neg_o,
  output logic        limit_hit_o
);

  logic [10:0] spd;
  assign spd = {8'd0, speed_i};

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    pos_o       = pos_i;
    dir_neg_o   = dir_neg_i;
    limit_hit_o = 1'b0;
    if (dir_neg_i) begin
      if (pos_i < spd) begin
        pos_o       = '0;
        dir_neg_o   = 1'b0;
        limit_hit_o = 1'b1;
      end else begin
        pos_o = pos_i - spd;
      end
    end else begin
      if (pos_i + spd >= limit_i) begin
        pos_o       = limit_i;
        dir_neg_o   = 1'b1;
        limit_hit_o = 1'b1;
      end else begin
        pos_o = pos_i + spd;
      end
    end
  end

endmodule

// File: rtl/pineball_game_ctrl.sv
// Pinball game sequencer: ball motion, score and lives, stepped once per
// FRAME_DIV frame ticks. Define PINEBALL_SPEEDUP_EN for the speed-ramp build.
module pineball_game_ctrl
  import pineball_pkg::*;
#(
  parameter int H_DISP      = 640,
  parameter int V_DISP      = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 64,
  parameter int PADDLE_Y    = 460,
  parameter int FRAME_DIV   = 2,
  parameter int SERVE_DELAY = 30,
  parameter int STEP        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] paddle_x,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       pos_valid,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [1:0] game_state
);

  localparam logic [10:0] CX    = 11'(H_DISP / 2 - BALL_SIZE / 2);
  localparam logic [10:0] CY    = 11'(V_DISP / 2 - BALL_SIZE / 2);
  localparam logic [10:0] X_LIM = 11'(H_DISP - BALL_SIZE);
  localparam logic [10:0] Y_LIM = 11'(PADDLE_Y - BALL_SIZE);
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int SW = $clog2(SERVE_DELAY + 1);

  game_state_e state_q, state_d;
  logic [10:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic        dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [7:0]  score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic        pos_valid_q, pos_valid_d;
  logic [SW-1:0] serve_cnt_q, serve_cnt_d;
  logic [FW-1:0] frame_cnt_q;
  logic        start_q;
  logic        start_rise, upd;
  logic [2:0]  speed;
  logic [10:0] x_next, y_next, px;
  logic        x_dir_next, y_dir_next, x_hit, y_hit;
  logic        y_paddle, overlap;

  assign start_rise = start & ~start_q;
  assign upd        = frame_tick && (frame_cnt_q == FW'(FRAME_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      start_q     <= 1'b0;
    end else begin
      start_q <= start;
      if (frame_tick) frame_cnt_q <= upd ? '0 : frame_cnt_q + FW'(1);
    end
  end

  pineball_axis_step u_step_x (
    .pos_i(pos_x_q), .dir_neg_i(dx_neg_q), .speed_i(speed), .limit_i(X_LIM),
    .pos_o(x_next), .dir_neg_o(x_dir_next), .limit_hit_o(x_hit)
  );

  pineball_axis_step u_step_y (
    .pos_i(pos_y_q), .dir_neg_i(dy_neg_q), .speed_i(speed), .limit_i(Y_LIM),
    .pos_o(y_next), .dir_neg_o(y_dir_next), .limit_hit_o(y_hit)
  );

  // Paddle overlap is judged on the pre-update x position.
  assign px       = {1'b0, paddle_x};
  assign y_paddle = y_hit && !dy_neg_q;
  assign overlap  = (pos_x_q + 11'(BALL_SIZE) > px) && (pos_x_q < px + 11'(PADDLE_W));

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    score_d     = score_q;
    lives_d     = lives_q;
    serve_cnt_d = serve_cnt_q;
    pos_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d     = ST_SERVE;
          score_d     = '0;
          lives_d     = LIVES_RESET;
          pos_x_d     = CX;
          pos_y_d     = CY;
          dx_neg_d    = 1'b0;
          dy_neg_d    = 1'b1;
          serve_cnt_d = '0;
        end
      end
      ST_SERVE: begin
        pos_x_d  = CX;
        pos_y_d  = CY;
        dx_neg_d = 1'b0;
        dy_neg_d = 1'b1;
        if (upd) begin
          if (serve_cnt_q == SW'(SERVE_DELAY - 1)) state_d = ST_RUN;
          else serve_cnt_d = serve_cnt_q + SW'(1);
        end
      end
      ST_RUN: begin
        if (upd) begin
          pos_valid_d = 1'b1;
          pos_x_d     = x_next;
          dx_neg_d    = x_dir_next;
          pos_y_d     = y_next;
          dy_neg_d    = y_dir_next;
          if (y_paddle) begin
            if (overlap) begin
              score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            end else begin
              lives_d     = lives_q - 2'd1;
              pos_x_d     = CX;
              pos_y_d     = CY;
              dx_neg_d    = 1'b0;
              dy_neg_d    = 1'b1;
              serve_cnt_d = '0;
              state_d     = (lives_q == 2'd1) ? ST_OVER : ST_SERVE;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pos_x_q     <= CX;
      pos_y_q     <= CY;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b1;
      score_q     <= '0;
      lives_q     <= LIVES_RESET;
      pos_valid_q <= 1'b0;
      serve_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      pos_valid_q <= pos_valid_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

`ifdef PINEBALL_SPEEDUP_EN
  logic [2:0] speed_q, speed_d;
  logic       paddle_hit;

  assign paddle_hit = (state_q == ST_RUN) && upd && y_paddle && overlap;

  // Speed ramps on every SPEEDUP_INTERVAL-th hit and restarts on each serve.
  always_comb begin
    speed_d = speed_q;
    if (state_d == ST_SERVE && state_q != ST_SERVE) begin
      speed_d = 3'd1;
    end else if (paddle_hit && score_d[SPEEDUP_BITS-1:0] == '0 && speed_q < 3'(SPEED_CAP)) begin
      speed_d = speed_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) speed_q <= 3'd1;
    else        speed_q <= speed_d;
  end

  assign speed = speed_q;
`else
  assign speed = 3'(STEP);
`endif

  assign pos_x      = pos_x_q[9:0];
  assign pos_y      = pos_y_q[9:0];
  assign pos_valid  = pos_valid_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_state = state_q;

endmodule
